// File: rtl/mmcm_reset_sequencer.sv
// Brings a chain of cascaded clock generators out of reset one channel at a time, then releases GLOBAL_RST.
// Optional macro LOCKLOSS_FILTER_EN: lock loss in RUN must persist LOCKLOSS_FILTER cycles to qualify.
module mmcm_reset_sequencer #(
    parameter int unsigned NUM_MMCM            = 2,
    parameter int unsigned CNT_W               = 16,
    parameter int unsigned DCM_RST_CYCLES      = 10000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned SETTLE_CYCLES       = 15000,
    parameter int unsigned MAX_RETRY           = 3,
    parameter int unsigned LOCKLOSS_FILTER     = 4
) (
    input  logic                CLK,
    input  logic                FORCE_RST_N,
    input  logic                SOFT_RST,
    input  logic [NUM_MMCM-1:0] DCM_LOCKED,
    output logic [NUM_MMCM-1:0] DCM_RST,
    output logic                GLOBAL_RST,
    output logic                LOCK_FAIL,
    output logic [3:0]          RETRY_CNT,
    output logic [2:0]          SEQ_STATE
);

    localparam int unsigned CH_W  = (NUM_MMCM > 1) ? $clog2(NUM_MMCM) : 1;
    localparam int unsigned RTY_W = 4;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    if (NUM_MMCM < 1 || NUM_MMCM > 8 || DCM_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
        SETTLE_CYCLES < 1 || MAX_RETRY > 15 || LOCKLOSS_FILTER < 1 ||
        (DCM_RST_CYCLES >> CNT_W) != 0 || (LOCK_TIMEOUT_CYCLES >> CNT_W) != 0 ||
        (SETTLE_CYCLES >> CNT_W) != 0) begin : g_bad_param
        $error("mmcm_reset_sequencer: illegal parameter set");
    end

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTY_W-1:0]    rty_q, rty_d;
    logic [RTY_W-1:0]    rtot_q, rtot_d;
    logic [NUM_MMCM-1:0] lk_q;
    logic [NUM_MMCM-1:0] dcm_rst_q, dcm_rst_d;
    logic                grst_q, grst_d;
    logic                fail_q, fail_d;

    logic                loss_found_c;
    logic [CH_W-1:0]     loss_idx_c;
    logic                run_loss_c;

    // Lowest already-locked channel that dropped during bring-up
    always_comb begin
        loss_found_c = 1'b0;
        loss_idx_c   = '0;
        for (int k = 0; k < int'(NUM_MMCM); k++) begin
            if (!loss_found_c && !lk_q[k] &&
                (state_q == ST_SETTLE || (state_q == ST_WAIT_LOCK && k < int'(ch_q)))) begin
                loss_found_c = 1'b1;
                loss_idx_c   = CH_W'(k);
            end
        end
    end

`ifdef LOCKLOSS_FILTER_EN
    localparam int unsigned FLT_W = $clog2(LOCKLOSS_FILTER + 1);

    logic [FLT_W-1:0] flt_q [NUM_MMCM];
    logic [FLT_W-1:0] flt_d [NUM_MMCM];

    always_comb begin
        run_loss_c = 1'b0;
        for (int k = 0; k < int'(NUM_MMCM); k++) begin
            flt_d[k] = '0;
            if (state_q == ST_RUN && !lk_q[k]) begin
                flt_d[k] = (flt_q[k] == FLT_W'(LOCKLOSS_FILTER)) ? flt_q[k] : flt_q[k] + FLT_W'(1);
            end
            if (flt_q[k] == FLT_W'(LOCKLOSS_FILTER)) begin
                run_loss_c = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge FORCE_RST_N) begin
        if (!FORCE_RST_N) begin
            for (int k = 0; k < int'(NUM_MMCM); k++) flt_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_MMCM); k++) flt_q[k] <= flt_d[k];
        end
    end
`else
    assign run_loss_c = ~&lk_q;
`endif

    // State and output registers; lock inputs pass through one sampling stage
    always_ff @(posedge CLK or negedge FORCE_RST_N) begin
        if (!FORCE_RST_N) begin
            state_q   <= ST_ASSERT;
            ch_q      <= '0;
            cnt_q     <= '0;
            rty_q     <= '0;
            rtot_q    <= '0;
            lk_q      <= '0;
            dcm_rst_q <= '1;
            grst_q    <= 1'b1;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            rty_q     <= rty_d;
            rtot_q    <= rtot_d;
            lk_q      <= DCM_LOCKED;
            dcm_rst_q <= dcm_rst_d;
            grst_q    <= grst_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q + CNT_W'(1);
        rty_d   = rty_q;
        rtot_d  = rtot_q;
        if (SOFT_RST) begin
            state_d = ST_ASSERT;
            ch_d    = '0;
            cnt_d   = '0;
            rty_d   = '0;
            rtot_d  = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == CNT_W'(DCM_RST_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (loss_found_c) begin
                        state_d = ST_ASSERT;
                        ch_d    = loss_idx_c;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end else if (lk_q[ch_q]) begin
                        rty_d   = '0;
                        cnt_d   = '0;
                        if (ch_q == CH_W'(NUM_MMCM - 1)) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_ASSERT;
                            ch_d    = ch_q + CH_W'(1);
                        end
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (rty_q < RTY_W'(MAX_RETRY)) begin
                            state_d = ST_ASSERT;
                            rty_d   = rty_q + RTY_W'(1);
                            rtot_d  = (rtot_q == '1) ? rtot_q : rtot_q + RTY_W'(1);
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (loss_found_c) begin
                        state_d = ST_ASSERT;
                        ch_d    = loss_idx_c;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (run_loss_c) begin
                        state_d = ST_ASSERT;
                        ch_d    = '0;
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_ASSERT;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        dcm_rst_d = '0;
        grst_d    = (state_d != ST_RUN);
        fail_d    = (state_d == ST_FAIL);
        for (int j = 0; j < int'(NUM_MMCM); j++) begin
            case (state_d)
                ST_ASSERT:    dcm_rst_d[j] = (j >= int'(ch_d));
                ST_WAIT_LOCK: dcm_rst_d[j] = (j > int'(ch_d));
                ST_FAIL:      dcm_rst_d[j] = 1'b1;
                default:      dcm_rst_d[j] = 1'b0;
            endcase
        end
    end

    assign DCM_RST    = dcm_rst_q;
    assign GLOBAL_RST = grst_q;
    assign LOCK_FAIL  = fail_q;
    assign RETRY_CNT  = rtot_q;
    assign SEQ_STATE  = state_q;

endmodule
